// File: rtl/decoder_pkg.sv
// decoder_pkg: shared word type plus the UART transmitter constants and state encoding.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state and the even-parity helper.
package decoder_pkg;

    localparam int unsigned WordWidth         = 32;
    localparam int unsigned UartDataBits      = 8;
    localparam int unsigned UartClkDivDefault = 104;
    localparam int unsigned UartBitCntW       = 3;

    typedef logic [WordWidth-1:0] word_t;

    // Frame states; PARITY exists only when the parity feature is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

`ifdef UART_TX_PARITY_EN
    // Even parity over one data byte.
    function automatic logic even_parity(input logic [UartDataBits-1:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: FIFO read handshake between a word FIFO (master) and the UART transmitter (slave).
//   data      : FIFO head word, only [7:0] is transmitted
//   have_next : FIFO holds at least one unread word (registered, lags the pop by one cycle)
//   next      : one-cycle pop strobe from the transmitter
interface uart_tx_if;
    import decoder_pkg::*;

    word_t data;
    logic  have_next;
    logic  next;

    modport master (output data, output have_next, input next);
    modport slave  (input data, input have_next, output next);

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART transmitter.
//   clk_i     : clock, rising edge
//   reset_i   : synchronous active-low reset
//   i_restart : hold the count at 0 (asserted while the transmitter is idle)
//   o_tick_c  : combinational, high for the last cycle of each bit period (count == ClkDiv-1)
module uart_baud_gen #(
    parameter int unsigned ClkDiv = 104
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_restart,
    output logic o_tick_c
);

    localparam int unsigned    CntW   = $clog2(ClkDiv);
    localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

    logic [CntW-1:0] r_cnt;

    // Counts 0..ClkDiv-1 and wraps, so every state change on a tick starts at 0.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == CntMax)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_tick_c = (r_cnt == CntMax);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter fed from a word FIFO; sends data[7:0] LSB first.
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-low reset; aborts any frame, the popped byte is dropped
//   fifo    : uart_tx_if.slave (data, have_next in; next pop strobe out)
//   tx      : serial line, idle high
//   busy    : frame in progress
// Parameters: ClkDiv (cycles per bit, 2..65535), StopBits (1 or 2).
// Optional feature macro: UART_TX_PARITY_EN adds one even-parity bit after the data bits.
// All outputs are registered, so tx and busy trail the state register by one cycle.
module uart_tx
    import decoder_pkg::*;
#(
    parameter int unsigned ClkDiv   = UartClkDivDefault,
    parameter int unsigned StopBits = 1
) (
    input  logic     clk_i,
    input  logic     reset_i,
    uart_tx_if.slave fifo,
    output logic     tx,
    output logic     busy
);

    localparam logic [UartBitCntW-1:0] LastDataBit = UartBitCntW'(UartDataBits - 1);
    localparam logic [UartBitCntW-1:0] LastStopBit = UartBitCntW'(StopBits - 1);

    uart_state_e             r_state;
    logic [UartDataBits-1:0] r_shift;
    logic [UartBitCntW-1:0]  r_bit_cnt;
    logic                    r_holdoff;
    logic                    r_next;
    logic                    r_tx;
    logic                    r_busy;
`ifdef UART_TX_PARITY_EN
    logic                    r_parity;
`endif

    logic w_tick;
    logic w_restart;
    logic w_pop;
    logic w_unused_data;

    // Upper word bits are never transmitted.
    assign w_unused_data = ^fifo.data[WordWidth-1:UartDataBits];

    // have_next lags the FIFO pointer, so it is ignored on the cycle after a pop.
    assign w_pop     = (r_state == ST_IDLE) && fifo.have_next && !r_holdoff;
    assign w_restart = (r_state == ST_IDLE);

    uart_baud_gen #(
        .ClkDiv(ClkDiv)
    ) u_baud_gen (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .i_restart(w_restart),
        .o_tick_c (w_tick)
    );

    // Frame sequencer with registered line, strobe and busy outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_holdoff <= 1'b0;
            r_next    <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_next    <= w_pop;
            r_holdoff <= w_pop;
            r_busy    <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= fifo.data[UartDataBits-1:0];
                        r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= even_parity(fifo.data[UartDataBits-1:0]);
`endif
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx <= 1'b0;
                    if (w_tick) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_tick) begin
                        r_shift   <= r_shift >> 1;
                        // Wraps 7->0, leaving the counter cleared for the stop bits.
                        r_bit_cnt <= r_bit_cnt + UartBitCntW'(1);
                        if (r_bit_cnt == LastDataBit) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    r_tx <= r_parity;
                    if (w_tick) begin
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_bit_cnt == LastStopBit) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + UartBitCntW'(1);
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo.next = r_next;
    assign tx        = r_tx;
    assign busy      = r_busy;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter ClkDiv, default 104, meaning clock cycles per bit period (legal range 2..65535).
REQ-002 The block SHALL have parameter StopBits, default 1, meaning stop bits per frame (1 or 2).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port data, input, 32 bits (word): the FIFO head word; only bits [7:0] are transmitted.
REQ-006 The block SHALL have port have_next, input, 1 bit: the FIFO holds at least one unread word.
REQ-007 The block SHALL have port next, output, 1 bit: a one-cycle pop strobe to the FIFO.
REQ-008 The block SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-010 The block SHALL implement states IDLE, START, DATA, PARITY (macro-only), and STOP.
REQ-011 In IDLE, when have_next=1 and the holdoff flag is clear, the block SHALL latch data[7:0] into a shift register, assert next for exactly that one cycle, and enter START on the next cycle.
REQ-012 After any next pulse, the block SHALL ignore have_next for the following cycle (holdoff), because have_next is registered and lags the FIFO pointer by one cycle.
REQ-013 The baud counter SHALL count 0..ClkDiv-1, reset to 0 on every state entry, and each bit SHALL last exactly ClkDiv cycles.
REQ-014 START SHALL drive tx=0 for one bit period, then go to DATA.
REQ-015 DATA SHALL drive tx from the shift register LSB first, shifting right at each bit end, for 8 bits tracked by a 3-bit counter that wraps 7->0, then go to PARITY (macro) or STOP.
REQ-016 STOP SHALL drive tx=1 for StopBits bit periods, then return to IDLE.
REQ-017 The frame latency SHALL be: tx falls exactly 1 cycle after the next pulse, and total frame length is (1+8+P+StopBits)*ClkDiv cycles, where P=1 with the macro and 0 without.
REQ-018 When have_next=1 at the end of STOP, the block SHALL pop on the first IDLE cycle, giving exactly 1 idle cycle between frames (back-to-back).
REQ-019 busy SHALL be 1 in every state except IDLE, and 0 on the cycle next is pulsed.
REQ-020 have_next and data changes during a frame SHALL NOT affect the frame in flight.
REQ-021 When the FIFO is empty (have_next=0), the block SHALL remain in IDLE with tx=1 indefinitely and never pulse next.

Reset
REQ-022 When reset_i=0 at a clock edge, the block SHALL enter IDLE with tx=1, next=0, busy=0, counters 0, shift register 0, and holdoff clear.
REQ-023 A reset mid-frame SHALL abort the frame immediately (tx=1 next cycle), and the popped byte SHALL be lost without re-popping.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, the block SHALL add a PARITY state after DATA that drives even parity (XOR of the 8 data bits) for one bit period.
REQ-025 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-026 The word typedef SHALL come from decoder_pkg, and the UART constants (UartDataBits=8, the default ClkDiv) SHALL be added to decoder_pkg.
REQ-027 The baud counter SHALL be a sub-module, uart_baud_gen, that takes a restart input and gives a one-cycle tick output at count ClkDiv-1.

Verification (bench ClkDiv=4, StopBits=1)
REQ-028 Verification: data=0x55 and have_next=1 -> next high 1 cycle, then tx = 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles, then IDLE.
REQ-029 Verification: two words 0xA5 and 0x3C queued -> exactly two next pulses 41 cycles apart, the frames back-to-back, and no third pulse.
REQ-030 Verification: have_next held 1 for 2 cycles after a pop (FIFO lag) -> only one next pulse.
REQ-031 Verification: reset_i=0 during DATA bit 3 -> tx=1, busy=0, next=0 on the following cycle, and no retransmission after reset releases while have_next=0.
REQ-032 Verification: with UART_TX_PARITY_EN defined and data=0x07 -> parity bit 1, frame 44 cycles; with data=0x03 -> parity bit 0.
REQ-033 Verification: data=0xFFFFFF00 -> eight 0 data bits, with upper bits ignored.
